// File: rtl/uart_prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg : shared state encoding, error codes and defaults for the loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/uart_prog_loader_if.sv
// ---------------------------------------------------------------------------
// uart_prog_loader_if : UART byte stream in, instruction-memory word write out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_prog_loader_if #(
  parameter int ADDR_W = 8
) ();

  logic [7:0]        rx_data;
  logic              rx_done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_data, rx_done,
    input  mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_done,
    output mem_we, mem_waddr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/uart_prog_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer : gathers 4 bytes little-endian; flags the completing byte
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_packer (
  input  wire        clk,
  input  wire        rst,
  input  wire        clear,
  input  wire        push,
  input  wire  [7:0] din,
  output logic [31:0] word,
  output logic       word_done
);

  logic [1:0]  idx;
  logic [31:0] shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx   <= 2'd0;
      shreg <= 32'd0;
    end else if (clear) begin
      idx   <= 2'd0;
      shreg <= 32'd0;
    end else if (push) begin
      idx   <= idx + 2'd1;
      shreg <= {din, shreg[31:8]};
    end
  end

  // Full word including the byte being pushed now, valid with word_done.
  assign word      = {din, shreg[31:8]};
  assign word_done = push && (idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader : parses A5|len32|words|xor frames into memory word writes
// Rev 1.0  -- optional inter-byte timeout: define UART_LOADER_TIMEOUT_EN
// ---------------------------------------------------------------------------
`default_nettype none

module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         MAX_WORDS   = 256,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 5000000
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               en,
  uart_prog_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  if (MAX_WORDS > (1 << ADDR_W) || MAX_WORDS < 1 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("uart_prog_loader: illegal parameter set");
  end

  state_t          state;
  logic [ADDR_W:0] len_words;
  logic [7:0]      csum;
  logic            push;
  logic            clear;
  logic [31:0]     word;
  logic            word_done;
  logic            last_word;

  assign push      = en && bus.rx_done && (state == LEN || state == DATA);
  assign clear     = !en || (state == IDLE);
  assign last_word = (word_count + CNT_ONE) == len_words;
  assign busy      = (state == LEN) || (state == DATA) || (state == CHK);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .din       (bus.rx_data),
    .word      (word),
    .word_done (word_done)
  );

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      error         <= ERR_NONE;
      word_count    <= '0;
      len_words     <= '0;
      csum          <= 8'd0;
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= 32'd0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else if (!en) begin
      // Dropping enable aborts any frame; a half-built word is discarded.
      state      <= IDLE;
      done       <= 1'b0;
      error      <= ERR_NONE;
      word_count <= '0;
      len_words  <= '0;
      csum       <= 8'd0;
      bus.mem_we <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          csum <= 8'd0;
          if (bus.rx_done && bus.rx_data == SYNC_BYTE) state <= LEN;
        end
        LEN: begin
          if (word_done) begin
            len_words <= word[ADDR_W:0];
            if (word > 32'(MAX_WORDS)) begin
              state <= ERR;
              error <= ERR_LEN;
            end else if (word == 32'd0) begin
              state <= CHK;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (push) begin
            csum <= csum ^ bus.rx_data;
            if (word_done) begin
              bus.mem_we    <= 1'b1;
              bus.mem_waddr <= word_count[ADDR_W-1:0];
              bus.mem_wdata <= word;
              if (word_count != MAX_CNT) word_count <= word_count + CNT_ONE;
              if (last_word) state <= CHK;
            end
          end
        end
        CHK: begin
          if (bus.rx_done) begin
            if (bus.rx_data == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= ERR_CSUM;
            end
          end
        end
        default: ;
      endcase
`ifdef UART_LOADER_TIMEOUT_EN
      if (!busy || bus.rx_done) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        tmo_cnt <= '0;
        state   <= ERR;
        error   <= ERR_TMO;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_ONE;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_loader : directed + random frames against a frame-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_prog_loader;
  import loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;
  localparam int TMO       = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en  = 1'b0;
  logic              busy;
  logic              done;
  logic [1:0]        error;
  logic [ADDR_W:0]   word_count;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_prog_loader #(
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (MAX_WORDS),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  tx_q[$];
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];
  logic        exp_done;
  logic [1:0]  exp_err;
  int          exp_wc;
  logic        prev_we = 1'b0;

  // Write monitor: records every write and checks writes are never back-to-back.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      check_eq("we_single_cycle", 64'(prev_we), 64'd0);
      obs_q.push_back({bus.mem_waddr, bus.mem_wdata});
    end
    prev_we = bus.mem_we;
  end

  // Frame-level reference: locate sync, read length, split into words, xor check.
  task automatic model();
    int          i;
    int          p;
    logic [31:0] len;
    logic [31:0] w;
    logic [7:0]  cs;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = ERR_NONE;
    exp_wc   = 0;
    i = 0;
    while (i < tx_q.size() && tx_q[i] != 8'hA5) i++;
    if (i + 4 >= tx_q.size()) return;
    len = {tx_q[i+4], tx_q[i+3], tx_q[i+2], tx_q[i+1]};
    p   = i + 5;
    if (len > 32'(MAX_WORDS)) begin
      exp_err = ERR_LEN;
      return;
    end
    cs = 8'd0;
    for (int k = 0; k < int'(len); k++) begin
      if (p + 3 >= tx_q.size()) return;
      w  = {tx_q[p+3], tx_q[p+2], tx_q[p+1], tx_q[p]};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      exp_q.push_back({8'(k), w});
      exp_wc = k + 1;
      p += 4;
    end
    if (p >= tx_q.size()) return;
    if (tx_q[p] == cs) exp_done = 1'b1;
    else               exp_err  = ERR_CSUM;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'($urandom);
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_all(input int max_gap);
    foreach (tx_q[i]) send_byte(tx_q[i], int'($urandom_range(0, max_gap)));
  endtask

  task automatic build_frame(input int len32, input bit good, input int n_junk);
    logic [7:0] b;
    logic [7:0] cs;
    logic [31:0] l;
    tx_q.delete();
    for (int j = 0; j < n_junk; j++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      tx_q.push_back(b);
    end
    l = 32'(len32);
    tx_q.push_back(8'hA5);
    for (int j = 0; j < 4; j++) tx_q.push_back(l[8*j +: 8]);
    if (len32 > MAX_WORDS || len32 < 0) begin
      for (int j = 0; j < 3; j++) tx_q.push_back(8'($urandom));
      return;
    end
    cs = 8'd0;
    for (int j = 0; j < 4 * len32; j++) begin
      b  = 8'($urandom);
      cs = cs ^ b;
      tx_q.push_back(b);
    end
    tx_q.push_back(good ? cs : (cs ^ 8'($urandom_range(1, 255))));
  endtask

  task automatic run_frame(input string tag, input int max_gap);
    int n;
    obs_q.delete();
    en = 1'b1;
    model();
    send_all(max_gap);
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check_eq({tag, "_addr"}, 64'(obs_q[k][39:32]), 64'(exp_q[k][39:32]));
      check_eq({tag, "_data"}, 64'(obs_q[k][31:0]),  64'(exp_q[k][31:0]));
    end
    check_eq({tag, "_done"},  64'(done),       64'(exp_done));
    check_eq({tag, "_error"}, 64'(error),      64'(exp_err));
    check_eq({tag, "_wcount"}, 64'(word_count), 64'(exp_wc));
    check_eq({tag, "_busy"},  64'(busy),       64'd0);
  endtask

  task automatic drop_en(input string tag);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq({tag, "_enlow_clear"}, 64'({busy, done, error, word_count}), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rx_data = 8'd0;
    bus.rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", 64'({bus.mem_we, busy, done, error, word_count}), 64'd0);
    check_eq("rst_waddr", 64'(bus.mem_waddr), 64'd0);
    check_eq("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Test 1: reference frame
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_frame("t1", 2);
    check_eq("t1_w0_const", 64'(obs_q.size() > 0 ? obs_q[0] : 40'hFF_FFFFFFFF), 64'({8'd0, 32'h44332211}));
    check_eq("t1_w1_const", 64'(obs_q.size() > 1 ? obs_q[1] : 40'hFF_FFFFFFFF), 64'({8'd1, 32'h88776655}));
    check_eq("t1_done_const", 64'({done, error, word_count}), 64'({1'b1, 2'd0, 9'd2}));
    drop_en("t1");

    // Test 2: bad checksum
    tx_q[13] = 8'h00;
    run_frame("t2", 1);
    check_eq("t2_err_const", 64'(error), 64'(ERR_CSUM));
    drop_en("t2");

    // Test 3: length 257
    tx_q = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h12, 8'h34};
    run_frame("t3", 1);
    check_eq("t3_err_const", 64'(error), 64'(ERR_LEN));
    drop_en("t3");

    // Test 4: junk then empty image
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("t4", 1);
    check_eq("t4_done_const", 64'(done), 64'd1);
    drop_en("t4");

    // Test 5: abort after 6th data byte, then reload from address 0
    obs_q.delete();
    en = 1'b1;
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_all(1);
    @(posedge clk); #1;
    check_eq("t5_busy_mid", 64'(busy), 64'd1);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t5_busy_abort", 64'(busy), 64'd0);
    check_eq("t5_wcount_abort", 64'(word_count), 64'd0);
    check_eq("t5_nwrites", 64'(obs_q.size()), 64'd1);
    check_eq("t5_w0", 64'(obs_q.size() > 0 ? obs_q[0] : 40'hFF_FFFFFFFF), 64'({8'd0, 32'h44332211}));
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_frame("t5_reload", 2);
    drop_en("t5");

    // Sync byte arriving in the same cycle en falls is dropped
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    bus.rx_data = 8'hA5;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    check_eq("en_fall_drop_busy", 64'(busy), 64'd0);
    drop_en("en_fall");

    // Test 6: stall inside DATA
    obs_q.delete();
    en = 1'b1;
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    send_all(0);
    repeat (TMO + 10) @(posedge clk);
    #1;
`ifdef UART_LOADER_TIMEOUT_EN
    check_eq("t6_error", 64'(error), 64'(ERR_TMO));
    check_eq("t6_busy", 64'(busy), 64'd0);
`else
    check_eq("t6_error", 64'(error), 64'(ERR_NONE));
    check_eq("t6_busy", 64'(busy), 64'd1);
`endif
    check_eq("t6_nwrites", 64'(obs_q.size()), 64'd0);
    drop_en("t6");

    // Boundary: largest legal image
    build_frame(MAX_WORDS, 1'b1, 0);
    run_frame("max_len", 0);
    drop_en("max_len");

    // Random frames
    for (int f = 0; f < 24; f++) begin
      int len32;
      bit good;
      len32 = int'($urandom_range(0, 12));
      good  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 6) == 0) len32 = MAX_WORDS + 1 + int'($urandom_range(0, 5000));
      build_frame(len32, good, int'($urandom_range(0, 3)));
      run_frame("rnd", 3);
      drop_en("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Sits between rx_controller and the instruction memory write port. Consumes the UART byte stream (rx_data/rx_done) while loading is enabled, parses a framed program image, assembles little-endian 32-bit words, and issues single-cycle word writes with incrementing word addresses. Reports busy/done/error status for the board LEDs.

Parameters:
ADDR_W, 8, width of the word write address.
MAX_WORDS, 256, largest accepted image length in words; must not exceed 2**ADDR_W.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYC, 5000000, maximum clk cycles allowed between bytes inside a frame (0.1 s at 50 MHz).

Ports:
clk  in  1  system clock (CLOCK_50 domain).
rst  in  1  reset; asynchronous, active-low.
en  in  1  loader enable (program mode); level.
rx_data  in  8  received byte; valid only when rx_done is high.
rx_done  in  1  single-cycle byte strobe.
mem_we  out  1  word write strobe, one cycle.
mem_waddr  out  ADDR_W  word address, 0-based.
mem_wdata  out  32  assembled word; first received byte goes to [7:0].
busy  out  1  high while in LEN, DATA or CHK.
done  out  1  image accepted; sticky.
error  out  2  0 = none, 1 = length too large, 2 = checksum mismatch, 3 = timeout; sticky.
word_count  out  ADDR_W+1  number of words written in the current frame.

Behaviour:
- Reset (async, rst low): state IDLE; all outputs 0; byte index, length, checksum and timer cleared.
- en low: synchronously forces IDLE and clears done, error, word_count and mem_we on the next edge. Bytes arriving while en is low are ignored.
- States:
  - IDLE: rx_done with rx_data == SYNC_BYTE -> LEN. Any other byte is discarded.
  - LEN: collects 4 bytes, little-endian, into len_words (32 bit). On the 4th byte:
    - len_words > MAX_WORDS -> ERR, error = 1.
    - len_words == 0 -> CHK.
    - otherwise -> DATA.
  - DATA: shifts bytes into the word buffer; the checksum XOR-accumulates every data byte.
    - On the 4th byte of a word, the next cycle has mem_we = 1, mem_wdata = word, mem_waddr = word_count. word_count increments in that same cycle.
    - After word len_words-1 is written -> CHK.
  - CHK: one byte. Equal to the XOR checksum -> DONE, done = 1. Otherwise -> ERR, error = 2.
  - DONE / ERR: terminal. All bytes are ignored until en falls or reset.
- Latency: mem_we is asserted exactly 1 cycle after the rx_done of the word's 4th byte.
- mem_we is never high for two consecutive cycles. mem_wdata and mem_waddr hold their values between writes.
- busy = (state is LEN, DATA or CHK).
- word_count saturates at MAX_WORDS. mem_waddr never wraps within a frame because the length check runs first.
- rx_done in the same cycle that en falls: en wins and the byte is dropped.
- A partial word (frame aborted mid-word) is never written.

Optional Feature:
UART_LOADER_TIMEOUT_EN.
- Defined: a counter resets on every rx_done and counts while in LEN, DATA or CHK. Reaching TIMEOUT_CYC-1 -> ERR, error = 3. The counter is held at 0 in IDLE, DONE and ERR.
- Undefined: no counter is instantiated and error code 3 is never produced.

Decomposition:
- Package loader_pkg:
  - state enum (IDLE, LEN, DATA, CHK, DONE, ERR);
  - error code constants (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TMO);
  - default SYNC_BYTE.
- One natural sub-module: byte_packer. It holds the 2-bit byte index and a 32-bit shift register, and flags word-complete; it is reused by both LEN and DATA.
- The timeout counter stays inline under the macro.

Test Plan:
1. Send en=1, bytes A5 02 00 00 00, 11 22 33 44, 55 66 77 88, then checksum 0x88.
   - Expect mem_we at addr 0 with data 0x44332211, then at addr 1 with data 0x88776655.
   - Expect done=1, error=0, word_count=2.
2. Send the same frame with a checksum byte of 0x00 -> both words written, error=2, done=0.
3. Send A5 01 01 00 00 (len 257) -> no mem_we, error=1.
4. Send junk 00 FF then A5 00 00 00 00 00 -> junk ignored, no writes, done=1.
5. Pull en low after the 6th data byte -> IDLE, busy=0, only word 0 written; a fresh frame then loads from addr 0.
6. With UART_LOADER_TIMEOUT_EN and TIMEOUT_CYC=100, stall 100 cycles inside DATA -> error=3. The same stall with the macro undefined -> stays in DATA with busy=1.
